// File: rtl/fft_downstream_pkg.sv
// Shared widths, bin constants and the complex-sample layout for the cross-spectrum peak finder.
// Pure declarations: no latency, no flow control.
package fft_downstream_pkg;
   localparam int DATA_W   = 16;
   localparam int IDX_W    = 7;
   localparam int MAG_W    = 2*DATA_W+2;
   localparam int NBINS    = 128;
   localparam int LAST_BIN = NBINS-1;
   localparam int PIPE_LAT = 4;

   // Imaginary part occupies the upper half of the FFT tdata word.
   typedef struct packed {
      logic signed [DATA_W-1:0] im;
      logic signed [DATA_W-1:0] re;
   } cplx_t;
endpackage

// File: rtl/fft_downstream_cmult_conj.sv
// Pipelined X*conj(Y): partial products in S1, full-precision sum/difference in S2.
// Latency 2 cycles, one sample per clock, no backpressure.
module cmult_conj #(
   parameter int DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [DATA_W-1:0]   xr,
   input  logic signed [DATA_W-1:0]   xi,
   input  logic signed [DATA_W-1:0]   yr,
   input  logic signed [DATA_W-1:0]   yi,
   output logic signed [2*DATA_W:0]   p_re,
   output logic signed [2*DATA_W:0]   p_im
);
   localparam int PW = 2*DATA_W;

   logic signed [PW-1:0] rr, ii, ir, ri;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr   <= '0;
         ii   <= '0;
         ir   <= '0;
         ri   <= '0;
         p_re <= '0;
         p_im <= '0;
      end else begin
         rr   <= PW'(xr) * PW'(yr);
         ii   <= PW'(xi) * PW'(yi);
         ir   <= PW'(xi) * PW'(yr);
         ri   <= PW'(xr) * PW'(yi);
         // One extra bit so -32768*-32768 sums cannot wrap.
         p_re <= (PW+1)'(rr) + (PW+1)'(ii);
         p_im <= (PW+1)'(ir) - (PW+1)'(ri);
      end
   end
endmodule

// File: rtl/fft_downstream.sv
// Cross-spectrum L1 peak search over bins 0..127; Max_Index updates 4 edges after bin 127 is presented.
// Accepts one bin per clock, no backpressure; Frame_Start clears the search and drops in-flight samples.
module fft_downstream #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 7
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              Frame_Start,
   input  logic [31:0]       x_m_axis_data_tdata,
   input  logic [31:0]       y_m_axis_data_tdata,
   input  logic [15:0]       x_m_axis_data_tuser,
   output logic [IDX_W-1:0]  Max_Index
);
   import fft_downstream_pkg::cplx_t;
   import fft_downstream_pkg::MAG_W;
   import fft_downstream_pkg::LAST_BIN;

   localparam int SUM_W = 2*DATA_W+1;

   cplx_t x_s, y_s;
   assign x_s = x_m_axis_data_tdata;
   assign y_s = y_m_axis_data_tdata;

   logic unused_tuser;
   assign unused_tuser = ^x_m_axis_data_tuser[15:IDX_W+1];

   logic signed [SUM_W-1:0] p_re, p_im;

   cmult_conj #(.DATA_W(DATA_W)) u_cmult (
      .clk  (clk),
      .rst  (reset_b),
      .xr   (x_s.re),
      .xi   (x_s.im),
      .yr   (y_s.re),
      .yi   (y_s.im),
      .p_re (p_re),
      .p_im (p_im)
   );

   logic [IDX_W-1:0] s1_idx, s2_idx, s3_idx;
   logic             s1_vld, s2_vld, s3_vld;
   logic [MAG_W-1:0] s3_mag;
   logic [SUM_W-1:0] abs_re, abs_im;

   assign abs_re = p_re[SUM_W-1] ? -p_re : p_re;
   assign abs_im = p_im[SUM_W-1] ? -p_im : p_im;

   // Index/in-band flag shadow the data pipeline; Frame_Start kills everything in flight.
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         s1_idx <= '0;
         s2_idx <= '0;
         s3_idx <= '0;
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         s3_vld <= 1'b0;
         s3_mag <= '0;
      end else begin
         s1_idx <= x_m_axis_data_tuser[IDX_W-1:0];
         s2_idx <= s1_idx;
         s3_idx <= s2_idx;
         s1_vld <= ~x_m_axis_data_tuser[IDX_W] & ~Frame_Start;
         s2_vld <= s1_vld & ~Frame_Start;
         s3_vld <= s2_vld & ~Frame_Start;
         s3_mag <= {1'b0, abs_re} + {1'b0, abs_im};
      end
   end

   logic [MAG_W-1:0] best_mag, win_mag;
   logic [IDX_W-1:0] best_idx, win_idx;

   always_comb begin
      win_mag = best_mag;
      win_idx = best_idx;
      if (s3_idx == '0) begin
         win_mag = s3_mag;
         win_idx = '0;
      end else if (s3_mag > best_mag) begin
         win_mag = s3_mag;
         win_idx = s3_idx;
      end
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         best_mag  <= '0;
         best_idx  <= '0;
         Max_Index <= '0;
      end else if (Frame_Start) begin
         best_mag <= '0;
         best_idx <= '0;
      end else if (s3_vld) begin
         best_mag <= win_mag;
         best_idx <= win_idx;
         if (s3_idx == IDX_W'(LAST_BIN))
            Max_Index <= win_idx;
      end
   end
endmodule

// File: tb/tb_fft_downstream.sv
// Directed bench for fft_downstream: per-bin stimulus tables, hand-computed winning indices.
`timescale 1ns/1ps
module tb_fft_downstream;
   import fft_downstream_pkg::*;

   logic              clk = 1'b0;
   logic              reset_b;
   logic              Frame_Start;
   logic [31:0]       x_m_axis_data_tdata;
   logic [31:0]       y_m_axis_data_tdata;
   logic [15:0]       x_m_axis_data_tuser;
   logic [IDX_W-1:0]  Max_Index;

   logic [31:0] xt [256];
   logic [31:0] yt [256];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fft_downstream #(.DATA_W(16), .IDX_W(7)) dut (
      .clk                 (clk),
      .reset_b             (reset_b),
      .Frame_Start         (Frame_Start),
      .x_m_axis_data_tdata (x_m_axis_data_tdata),
      .y_m_axis_data_tdata (y_m_axis_data_tdata),
      .x_m_axis_data_tuser (x_m_axis_data_tuser),
      .Max_Index           (Max_Index)
   );

   task automatic check_eq(input string tag, input logic [IDX_W-1:0] got, input logic [IDX_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_tab();
      for (int b = 0; b < 256; b++) begin
         xt[b] = '0;
         yt[b] = '0;
      end
   endtask

   task automatic set_bin(input int b, input int xr, input int xi, input int yr, input int yi);
      xt[b] = {xi[15:0], xr[15:0]};
      yt[b] = {yi[15:0], yr[15:0]};
   endtask

   task automatic step(input int b, input logic fs);
      @(negedge clk);
      x_m_axis_data_tdata = xt[b];
      y_m_axis_data_tdata = yt[b];
      x_m_axis_data_tuser = 16'(b);
      Frame_Start         = fs;
   endtask

   task automatic stream(input int lo, input int hi, input int rep);
      for (int b = lo; b <= hi; b++)
         for (int r = 0; r < rep; r++)
            step(b, 1'b0);
   endtask

   // Called right after bin 127 is driven; returns once its result is visible.
   task automatic drain();
      for (int k = 1; k < PIPE_LAT; k++)
         step(127 + k, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      reset_b             = 1'b1;
      Frame_Start         = 1'b0;
      x_m_axis_data_tdata = '0;
      y_m_axis_data_tdata = '0;
      x_m_axis_data_tuser = '0;
      clear_tab();
      repeat (3) @(negedge clk);
      check_eq("reset_value", Max_Index, 7'd0);
      reset_b = 1'b0;

      // Single peak at bin 37 (M = 5000), with exact latency.
      set_bin(37, 100, 0, 50, 0);
      stream(0, 127, 1);
      step(128, 1'b0);
      step(129, 1'b0);
      @(negedge clk);
      check_eq("peak_before_edge4", Max_Index, 7'd0);
      @(negedge clk);
      check_eq("peak_at_edge4", Max_Index, 7'd37);
      stream(130, 255, 1);
      repeat (PIPE_LAT) @(negedge clk);
      check_eq("peak_oob_tail", Max_Index, 7'd37);

      // Conjugate: bin 10 M=10000 beats bin 20 M=6000.
      clear_tab();
      set_bin(10, 0, 100, 0, 100);
      set_bin(20, 100, 0, 0, -60);
      stream(0, 127, 1);
      drain();
      check_eq("conj_basic", Max_Index, 7'd10);

      // Bin 40 gives 2500 with conj(Y) but 3100 with plain X*Y; bin 41 gives 2800.
      clear_tab();
      set_bin(40, 30, 40, 30, 40);
      set_bin(41, 56, 0, 50, 0);
      stream(0, 127, 1);
      drain();
      check_eq("conj_sign", Max_Index, 7'd41);

      // Tie between 5 and 9, out-of-band 200 huge, every bin stalled 3 cycles.
      clear_tab();
      set_bin(5, 20, 0, 20, 0);
      set_bin(9, 20, 0, 20, 0);
      set_bin(200, 1000, 0, 1000, 0);
      stream(0, 127, 3);
      drain();
      check_eq("tie_low_index", Max_Index, 7'd5);
      stream(131, 255, 3);
      repeat (PIPE_LAT) @(negedge clk);
      check_eq("oob_ignored", Max_Index, 7'd5);

      // Frame_Start during idx 50 drops bin 12 and in-flight bins 47..49.
      clear_tab();
      set_bin(12, 90, 0, 100, 0);
      set_bin(47, 20, 0, 20, 0);
      set_bin(48, 20, 0, 20, 0);
      set_bin(49, 20, 0, 20, 0);
      set_bin(90, 10, 0, 10, 0);
      stream(0, 49, 1);
      step(50, 1'b1);
      step(51, 1'b0);
      check_eq("fs_holds_max", Max_Index, 7'd5);
      stream(52, 126, 1);
      check_eq("fs_holds_late", Max_Index, 7'd5);
      step(127, 1'b0);
      drain();
      check_eq("fs_result", Max_Index, 7'd90);

      // Frame_Start coinciding with bin 127 at the compare stage blocks the load.
      clear_tab();
      set_bin(60, 20, 0, 20, 0);
      stream(0, 127, 1);
      step(128, 1'b0);
      step(129, 1'b0);
      step(130, 1'b1);
      step(131, 1'b0);
      check_eq("fs_beats_last", Max_Index, 7'd90);

      // Extremes: bin 127 M = 2^31 must beat bin 60 M = 32767^2.
      clear_tab();
      set_bin(60, 32767, 0, 32767, 0);
      set_bin(127, -32768, -32768, -32768, -32768);
      stream(0, 127, 1);
      drain();
      check_eq("extreme_no_wrap", Max_Index, 7'd127);

      // Asynchronous reset mid-frame, then idle inputs.
      clear_tab();
      set_bin(30, 100, 0, 100, 0);
      stream(0, 60, 1);
      #2 reset_b = 1'b1;
      #1 check_eq("reset_async", Max_Index, 7'd0);
      @(negedge clk);
      x_m_axis_data_tdata = '0;
      y_m_axis_data_tdata = '0;
      x_m_axis_data_tuser = '0;
      @(negedge clk);
      reset_b = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("reset_idle_hold", Max_Index, 7'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
